mtt_tick_gen: RTL

- Parametrised multi-channel tick/toggle generator for the MTT subsystem. It supplies periodic timebase pulses and square-wave levels to MTT housekeeping logic, such as scrub and refresh sweeps.
- Each channel has a programmable period, a mode (TOGGLE or PULSE) and an enable. All are written through a valid/ready config port.
- With default parameters, channel 0 reproduces a divide-by-2 toggle out of reset.

---
 rtl/mtt_pkg.sv | 23 ++
 rtl/mtt_tick_gen_if.sv | 28 ++
 rtl/mtt_tick_chan.sv | 86 ++++++++
 rtl/mtt_tick_gen.sv | 67 ++++++
 4 files changed

// File: rtl/mtt_pkg.sv
// Shared types for the MTT tick generator: channel modes, config record and
// the channel-index width helper used by the interface and the top level.
package mtt_pkg;

  typedef enum logic {
    MTT_TICK_TOGGLE = 1'b0,
    MTT_TICK_PULSE  = 1'b1
  } mtt_tick_mode_e;

  localparam int MTT_TICK_CNT_W = 16;

  typedef struct packed {
    logic [MTT_TICK_CNT_W-1:0] period;
    mtt_tick_mode_e            mode;
    logic                      en;
  } mtt_tick_cfg_t;

  // A single-channel build still needs a 1-bit channel select.
  function automatic int unsigned mtt_ch_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mtt_tick_gen_if.sv
// Valid/ready configuration port of the MTT tick generator.
interface mtt_tick_gen_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
);
  import mtt_pkg::*;

  localparam int CH_W = mtt_ch_w(N_CH);

  logic                 valid;
  logic                 ready;
  logic [CH_W-1:0]      ch;
  logic [CNT_W-1:0]     period;
  mtt_tick_mode_e       mode;
  logic                 en;
  logic                 err;

  modport master (
    output valid, ch, period, mode, en,
    input  ready, err
  );

  modport slave (
    input  valid, ch, period, mode, en,
    output ready, err
  );

endinterface

// File: rtl/mtt_tick_chan.sv
// One tick/toggle channel: counter, shadow/active period, mode, enable and the
// registered tick and level outputs.
module mtt_tick_chan
  import mtt_pkg::*;
#(
  parameter int             CNT_W      = 16,
  parameter logic [CNT_W-1:0] DEF_PERIOD = '0,
  parameter mtt_tick_mode_e DEF_MODE   = MTT_TICK_TOGGLE,
  parameter logic           DEF_EN     = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] period_i,
  input  mtt_tick_mode_e   mode_i,
  input  logic             en_i,
  output logic             tick_o,
  output logic             level_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] shadow_q;
  logic [CNT_W-1:0] active_q;
  mtt_tick_mode_e   mode_q;
  logic             en_q;
  logic             tick_q;
  logic             level_q;

  logic             en_eff;
  mtt_tick_mode_e   mode_eff;
  logic             wrap;
  logic             load_en;
  logic             run;

  // Mode and enable written this cycle already steer this cycle's update.
  assign en_eff   = wr_i ? en_i : en_q;
  assign mode_eff = wr_i ? mode_i : mode_q;
  assign wrap     = (cnt_q == active_q);
  assign load_en  = wr_i && en_i && !en_q;
  assign run      = en_eff && !load_en && !clear_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      shadow_q <= DEF_PERIOD;
      active_q <= DEF_PERIOD;
      mode_q   <= DEF_MODE;
      en_q     <= DEF_EN;
      tick_q   <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      if (wr_i) begin
        shadow_q <= period_i;
        mode_q   <= mode_i;
        en_q     <= en_i;
      end

      // A fresh enable starts straight from the written period; otherwise the
      // shadow value (before this cycle's write) is adopted only at a wrap.
      if (load_en) begin
        active_q <= period_i;
      end else if (run && wrap) begin
        active_q <= shadow_q;
      end

      if (run && !wrap) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end

      tick_q <= run && wrap;

      if (clear_i) begin
        level_q <= 1'b0;
      end else if (run && wrap && (mode_eff == MTT_TICK_TOGGLE)) begin
        level_q <= ~level_q;
      end
    end
  end

  assign tick_o  = tick_q;
  assign level_o = level_q;

endmodule

// File: rtl/mtt_tick_gen.sv
// Multi-channel tick/toggle timebase: decodes config writes to channels,
// flags out-of-range writes and fans clear out to every channel.
module mtt_tick_gen
  import mtt_pkg::*;
#(
  parameter int               N_CH       = 4,
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] DEF_PERIOD = '0,
  parameter mtt_tick_mode_e   DEF_MODE   = MTT_TICK_TOGGLE,
  parameter logic [N_CH-1:0]  DEF_EN     = {N_CH{1'b1}}
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  mtt_tick_gen_if.slave   cfg,
  output logic [N_CH-1:0] tick_o,
  output logic [N_CH-1:0] level_o
);

  localparam int CH_W = mtt_ch_w(N_CH);

  logic ready_q;
  logic err_q;
  logic accept;
  logic ch_oob;

  assign accept = cfg.valid && ready_q;
  assign ch_oob = 32'(cfg.ch) >= N_CH;

  // Ready rises on the first edge after reset and then stays high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      err_q   <= accept && ch_oob;
    end
  end

  assign cfg.ready = ready_q;
  assign cfg.err   = err_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    logic wr;

    assign wr = accept && (cfg.ch == CH_W'(i));

    mtt_tick_chan #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_MODE   (DEF_MODE),
      .DEF_EN     (DEF_EN[i])
    ) u_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .wr_i     (wr),
      .period_i (cfg.period),
      .mode_i   (cfg.mode),
      .en_i     (cfg.en),
      .tick_o   (tick_o[i]),
      .level_o  (level_o[i])
    );
  end

endmodule
